// File: rtl/ret_stack_pkg.sv
// ---------------------------------------------------------------------------
// ret_stack_pkg
//   Processor-wide definitions shared by the PC register, incrementer, PC mux
//   and the hardware return-address stack (RAS).
//   - PC_W       : program-counter / return-address width
//   - RAS_DEPTH  : default number of RAS entries
//   - ras_op_e   : operation decoded from the push/pop request pair
// ---------------------------------------------------------------------------
package ret_stack_pkg;

  localparam int PC_W      = 10;
  localparam int RAS_DEPTH = 8;

  typedef enum logic [1:0] {
    RAS_IDLE    = 2'b00,
    RAS_POP     = 2'b01,
    RAS_PUSH    = 2'b10,
    RAS_REPLACE = 2'b11
  } ras_op_e;

  // push maps to bit 1 and pop to bit 0, so the request pair is the opcode.
  function automatic ras_op_e ras_decode(input logic push, input logic pop);
    return ras_op_e'({push, pop});
  endfunction

endpackage : ret_stack_pkg

// File: rtl/ret_stack_if.sv
// ---------------------------------------------------------------------------
// ret_stack_if
//   Connection between the control unit (master) and the return-address
//   stack (slave).
//   master drives : push, pop, push_data
//   slave drives  : top, count, empty, full, overflow, underflow
// ---------------------------------------------------------------------------
interface ret_stack_if #(
  parameter int PC_W  = ret_stack_pkg::PC_W,
  parameter int DEPTH = ret_stack_pkg::RAS_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
);

  logic             push;
  logic             pop;
  logic [PC_W-1:0]  push_data;
  logic [PC_W-1:0]  top;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, push_data,
    input  top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data,
    output top, count, empty, full, overflow, underflow
  );

endinterface : ret_stack_if

// File: rtl/ret_stack_mem.sv
// ---------------------------------------------------------------------------
// ret_stack_mem
//   DEPTH x PC_W register array: one synchronous write port, one
//   asynchronous read port. Contents are not reset.
//   clk_i    : write clock (rising edge)
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : write data
//   raddr_i  : read index
//   rdata_o  : combinational read data
// ---------------------------------------------------------------------------
module ret_stack_mem #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [PC_W-1:0]  wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [PC_W-1:0]  rdata_o
);

  logic [PC_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the stack's count,
  // so resetting storage would only cost flops and block RAM mapping.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : ret_stack_mem

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
//   Hardware return-address stack. JAL pushes PC+1; RET consumes the
//   registered top as next PC and pops it on the same edge.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : ret_stack_if.slave
//            push/pop/push_data in; top/count/empty/full/overflow/underflow out
// ---------------------------------------------------------------------------
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int PC_W  = ret_stack_pkg::PC_W,
  parameter int DEPTH = ret_stack_pkg::RAS_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        reset,
  ret_stack_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  top_q, top_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [IDX_W-1:0] mem_raddr;
  logic [PC_W-1:0]  mem_rdata;

  logic    is_empty;
  logic    is_full;
  ras_op_e op;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_FULL);
  assign op       = ras_decode(bus.push, bus.pop);

  // Entry below the top, used as the new top on a pop. Only meaningful when
  // count >= 2; otherwise the index is pinned to 0 to stay in range.
  always_comb begin
    mem_raddr = '0;
    if (count_q >= CNT_TWO) begin
      mem_raddr = IDX_W'(count_q - CNT_TWO);
    end
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_d   = count_q;
    top_d     = top_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = '0;

    unique case (op)
      RAS_PUSH: begin
        if (is_full) begin
          ovf_d = 1'b1;  // no wrap: the oldest return address is kept
        end else begin
          mem_we    = 1'b1;
          mem_waddr = IDX_W'(count_q);
          top_d     = bus.push_data;
          count_d   = count_q + CNT_ONE;
        end
      end
      RAS_POP: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          count_d = count_q - CNT_ONE;
          top_d   = (count_q >= CNT_TWO) ? mem_rdata : '0;
        end
      end
      RAS_REPLACE: begin
        // Return then call in one cycle: overwrite the top in place. On an
        // empty stack this degenerates to a plain push.
        mem_we  = 1'b1;
        top_d   = bus.push_data;
        if (is_empty) begin
          mem_waddr = '0;
          count_d   = CNT_ONE;
        end else begin
          mem_waddr = IDX_W'(count_q - CNT_ONE);
        end
      end
      default: ;  // RAS_IDLE: hold
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  ret_stack_mem #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (bus.push_data),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  assign bus.top       = top_q;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule : ret_stack

// File: tb/tb_ret_stack.sv
// ---------------------------------------------------------------------------
// tb_ret_stack
//   Directed self-checking bench for ret_stack (PC_W=10, DEPTH=8).
//   Inputs change 1 ns after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_ret_stack;

  localparam int PC_W  = 10;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk;
  logic reset;

  int n_assert = 0;
  int n_fail   = 0;

  ret_stack_if #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  ret_stack #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request, then return inputs to idle.
  task automatic step(input logic p, input logic q, input logic [PC_W-1:0] d);
    bus.push      = p;
    bus.pop       = q;
    bus.push_data = d;
    @(posedge clk);
    #1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".top"},       16'(bus.top),       16'h0);
    check({tag, ".count"},     16'(bus.count),     16'h0);
    check({tag, ".empty"},     16'(bus.empty),     16'h1);
    check({tag, ".full"},      16'(bus.full),      16'h0);
    check({tag, ".overflow"},  16'(bus.overflow),  16'h0);
    check({tag, ".underflow"}, 16'(bus.underflow), 16'h0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset state, then one idle cycle
    check_idle("rst");
    step(1'b0, 1'b0, '0);
    check_idle("idle");

    // 2: push three, pop three
    step(1'b1, 1'b0, 10'h011);
    check("p1.top", 16'(bus.top), 16'h011);
    step(1'b1, 1'b0, 10'h022);
    check("p2.top", 16'(bus.top), 16'h022);
    step(1'b1, 1'b0, 10'h033);
    check("p3.top",   16'(bus.top),   16'h033);
    check("p3.count", 16'(bus.count), 16'd3);
    check("pop1.pre", 16'(bus.top), 16'h033);
    step(1'b0, 1'b1, '0);
    check("pop2.pre", 16'(bus.top), 16'h022);
    step(1'b0, 1'b1, '0);
    check("pop3.pre", 16'(bus.top), 16'h011);
    step(1'b0, 1'b1, '0);
    check("pop3.top",   16'(bus.top),   16'h0);
    check("pop3.empty", 16'(bus.empty), 16'h1);
    check("pop3.count", 16'(bus.count), 16'h0);

    // 1b: asynchronous reset mid-operation after three pushes
    step(1'b1, 1'b0, 10'h0A1);
    step(1'b1, 1'b0, 10'h0A2);
    step(1'b1, 1'b0, 10'h0A3);
    check("pre_arst.count", 16'(bus.count), 16'd3);
    #2;
    reset = 1'b1;
    #1;
    check_idle("arst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 3: fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, PC_W'(10'h100 + i));
    end
    check("fill.full",  16'(bus.full),  16'h1);
    check("fill.count", 16'(bus.count), 16'd8);
    check("fill.top",   16'(bus.top),   16'h107);
    check("fill.ovf",   16'(bus.overflow), 16'h0);
    step(1'b1, 1'b0, 10'h3FF);
    check("ovf.top",   16'(bus.top),      16'h107);
    check("ovf.count", 16'(bus.count),    16'd8);
    check("ovf.flag",  16'(bus.overflow), 16'h1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d.pre", i), 16'(bus.top), 16'(16'h107 - i));
      step(1'b0, 1'b1, '0);
    end
    check("drain.top",   16'(bus.top),      16'h0);
    check("drain.empty", 16'(bus.empty),    16'h1);
    check("drain.ovf",   16'(bus.overflow), 16'h1);
    check("drain.unf",   16'(bus.underflow), 16'h0);
    pulse_reset();
    check("clr.ovf", 16'(bus.overflow), 16'h0);

    // 4: underflow, sticky across a later push
    step(1'b0, 1'b1, '0);
    check("unf.flag",  16'(bus.underflow), 16'h1);
    check("unf.count", 16'(bus.count),     16'h0);
    check("unf.top",   16'(bus.top),       16'h0);
    step(1'b1, 1'b0, 10'h055);
    check("unf_push.top",   16'(bus.top),       16'h055);
    check("unf_push.count", 16'(bus.count),     16'd1);
    check("unf_push.unf",   16'(bus.underflow), 16'h1);
    pulse_reset();

    // 5: simultaneous push/pop replaces the top
    step(1'b1, 1'b0, 10'h010);
    step(1'b1, 1'b0, 10'h020);
    step(1'b1, 1'b1, 10'h0AA);
    check("rep.count", 16'(bus.count), 16'd2);
    check("rep.top",   16'(bus.top),   16'h0AA);
    step(1'b0, 1'b1, '0);
    check("rep_pop.top",   16'(bus.top),   16'h010);
    check("rep_pop.count", 16'(bus.count), 16'd1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      step(1'b1, 1'b0, PC_W'(10'h200 + i));
    end
    check("rfull.count", 16'(bus.count), 16'd8);
    check("rfull.top",   16'(bus.top),   16'h206);
    step(1'b1, 1'b1, 10'h2AB);
    check("repf.count", 16'(bus.count),    16'd8);
    check("repf.top",   16'(bus.top),      16'h2AB);
    check("repf.full",  16'(bus.full),     16'h1);
    check("repf.ovf",   16'(bus.overflow), 16'h0);
    step(1'b0, 1'b1, '0);
    check("repf_pop.top", 16'(bus.top), 16'h205);
    pulse_reset();

    // 6: simultaneous push/pop on empty behaves as a push
    step(1'b1, 1'b1, 10'h123);
    check("rep0.count", 16'(bus.count),     16'd1);
    check("rep0.top",   16'(bus.top),       16'h123);
    check("rep0.unf",   16'(bus.underflow), 16'h0);
    step(1'b0, 1'b1, '0);
    check("rep0_pop.top",   16'(bus.top),   16'h0);
    check("rep0_pop.empty", 16'(bus.empty), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_ret_stack

// File: doc/ret_stack.md
Name: ret_stack

Overview:
- Hardware return-address stack that sits directly downstream of the control unit's we_stack / s_jret outputs.
- JAL pushes the link address (PC+1).
- RET uses the current top as next PC and pops it in the same cycle.
- The top is a registered output, so it is stable before the RET edge.
- The PC mux selects top when s_jret=1.

Parameters:
- PC_W, 10, width of program-counter / return address.
- DEPTH, 8, number of stack entries; must be ≥2.
- CNT_W, $clog2(DEPTH+1), width of occupancy count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  push request; driven by the control unit's we_stack.
- pop  input  1  pop request; driven by the control unit's s_jret.
- push_data  input  PC_W  return address to push (PC+1 from the incrementer).
- top  output  PC_W  registered current top-of-stack; 0 when empty.
- count  output  CNT_W  number of valid entries.
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- overflow  output  1  sticky: a push was attempted while full.
- underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (async, any time, including mid-operation): top=0, count=0, overflow=0, underflow=0, empty=1, full=0. Entry memory contents are don't-care after reset.
- All state changes occur on the rising edge of clk. empty and full are combinational decodes of count.
- Internal pointer sp equals count; entries occupy mem[0..count-1]; top mirrors mem[count-1].
- Push only (push=1, pop=0, not full):
  - mem[count] <= push_data; top <= push_data; count <= count+1.
  - 1-cycle latency: the new top is visible the next cycle.
- Push while full (push=1, pop=0):
  - No change to mem, top or count; overflow <= 1.
  - The oldest entry is NOT discarded; there is no wrap-around.
- Pop only (push=0, pop=1, not empty):
  - count <= count-1.
  - top <= mem[count-2] if count≥2, else 0.
  - The consumer samples top in the same cycle pop is high (before the edge).
- Pop while empty: no state change except underflow <= 1; top stays 0.
- Simultaneous push and pop, count≥1:
  - Replace top: mem[count-1] <= push_data; top <= push_data; count unchanged.
  - Legal even when full; no overflow.
- Simultaneous push and pop, count==0:
  - Treated as push only: count <= 1, top <= push_data.
  - No underflow.
- push=pop=0: hold all state.
- overflow and underflow clear only on reset.
- Read of mem[count-2] is combinational from the register array. There is no read-during-write hazard: write and read indices differ in every legal case.
- Widths: count arithmetic is done in CNT_W bits. Index arithmetic is guarded so that mem is never indexed outside 0..DEPTH-1.

Decomposition:
- Shared processor package holds:
  - PC_W (shared with the PC register, incrementer and PC mux).
  - Default RAS DEPTH.
- One natural sub-module: ret_stack_mem, a DEPTH×PC_W register array with one synchronous write port and one asynchronous read port; no reset on the array.
- Pointer/count/top/flag logic stays in ret_stack.

Test Plan:
1. Reset then idle: after reset release → top=0, count=0, empty=1, full=0, overflow=0, underflow=0. Assert reset mid-sequence after 3 pushes → same values immediately, asynchronously.
2. Push 0x011, 0x022, 0x033 on consecutive cycles → top=0x011, then 0x022, then 0x033; count=3. Pop three times → top reads 0x033, 0x022, 0x011 before each pop edge; after the last pop top=0, empty=1.
3. Push 8 values 0x100..0x107 → full=1, count=8, top=0x107. Push 0x3FF → top stays 0x107, count stays 8, overflow=1. Then 8 pops return 0x107..0x100 in order.
4. Pop on empty → underflow=1, count=0, top=0. Then push 0x055 → top=0x055, count=1, underflow remains 1.
5. With stack holding 0x010, 0x020, assert push=pop=1 with push_data=0x0AA → count=2, top=0x0AA. Next pop → top=0x010. Repeat push=pop=1 while full → count=8, no overflow.
6. push=pop=1 on empty with push_data=0x123 → count=1, top=0x123, underflow=0.
